tlul_data_integ_enc_buf: RTL and testbench
==========================================

// Module: tlul_data_integ_enc_buf
// PURPOSE
//  Transmit-side counterpart of the TL-UL data integrity check. Accepts 32-bit payload words over a
//  valid/ready handshake and computes the 7-bit inverted SECDED (39,32) integrity code. Emits the
//  39-bit codeword through a 2-entry skid buffer, so full throughput and registered outputs both hold.
//  A redundant re-decode of the head entry raises a sticky fault alert. Sits in front of any TL-UL
//  host/device that must supply d_user/a_user data integrity.
// PARAMETERS
//  DataWidth     32  payload width; only 32 is legal (elaboration error otherwise)
//  IntgWidth      7  integrity bits; only 7 is legal
//  EnableCheck    1  1: re-decode head entry and drive alert; 0: intg_fault_o tied 0
// PORTS
//  clk_i         in   1   clock
//  rst_i         in   1   synchronous, active-high reset
//  valid_i       in   1   payload valid
//  ready_o       out  1   buffer can accept (registered: 1 when fewer than 2 entries held)
//  data_i        in   32  payload word
//  valid_o       out  1   codeword valid (1 when at least 1 entry held)
//  ready_i       in   1   downstream accepts
//  data_intg_o   out  39  {intg[6:0], data[31:0]} of head entry
//  count_o       out  2   entries held, 0..2
//  intg_fault_o  out  1   sticky: head entry failed re-decode
// BEHAVIOUR
//  - Reset (rst_i high at a clock edge): count=0, valid_o=0, ready_o=1, data_intg_o=0,
//    intg_fault_o=0. Takes priority over any handshake in the same cycle; in-flight entries are discarded.
//  - Encode: c=39'(data); c[32+k]=^(c & M_k) with
//    M = {0x002606BD25, 0x00DEBA8050, 0x00413D89AA, 0x0031234ED1, 0x00C2C1323B, 0x002DCC624C, 0x0098505586}
//    for k=0..6; then c ^= 39'h2A_0000_0000. Combinational on data_i; stored codeword only.
//  - Push = valid_i & ready_o; pop = valid_o & ready_i. Latency is 1 cycle: a word pushed at edge N
//    is on data_intg_o after edge N.
//  - States: EMPTY(count 0), ONE(1), FULL(2).
//  - EMPTY: push -> ONE, and the word goes to the head entry.
//  - ONE: push & !pop -> FULL, word to the skid entry. Push & pop -> ONE, head replaced by the new word.
//    Pop only -> EMPTY.
//  - FULL: ready_o=0, so push is impossible. Pop -> ONE and the skid entry moves to the head.
//  - valid_i with ready_o=0 is not consumed; the source must hold data. Output holds data_intg_o
//    stable while valid_o & !ready_i.
//  - data_intg_o is the stored head register, not muxed combinationally from data_i.
//  - Order is strictly FIFO. No loss and no duplication under any valid/ready pattern.
//  - Check (EnableCheck=1): when valid_o, decode the head with the inv 39_32 decoder. Any nonzero error
//    sets intg_fault_o at the next edge. It stays set until reset and does not stall the datapath.
//  - Empty-buffer data_intg_o keeps its last value; this value is don't-care and must not trigger the check.
// STRUCTURE
//  - Shared package tlul_pkg: DataMaxWidth=32, DataIntgWidth=7, plus the inverted-code constant 7'h2A.
//  - Sub-module prim_secded_inv_39_32_enc: combinational encoder, one instance on data_i.
//  - The check reuses the existing prim_secded_inv_39_32_dec. The wrapper owns only the skid buffer
//    FSM and the sticky flag.
// TESTING
//  - Reset, then push 0x00000000 -> next cycle valid_o=1, data_intg_o=39'h2A_0000_0000, intg_fault_o=0.
//  - Random stream of 1000 words, ready_i=1 throughout -> one word per cycle.
//    Every codeword passes the reference decoder with err=0, in order.
//  - Hold ready_i=0, push 0x11111111 and 0x22222222 -> count_o=2, ready_o=0. A third word is held.
//    Release ready_i -> three words out in order.
//  - Random valid_i/ready_i (50% each) for 10k cycles -> scoreboard exact FIFO match.
//    count_o stays within 0..2; output is stable while stalled.
//  - Assert rst_i while FULL and pushing -> next cycle count_o=0, valid_o=0, ready_o=1.
//    No stale word emerges afterwards.
//  - Force one bit of the stored head entry -> intg_fault_o=1 one cycle later.
//    It stays 1 after the pop and clears only on rst_i.

Source files
------------

// File: rtl/tlul_pkg.sv
// Shared TL-UL constants: data/integrity widths, inverted-code constant,
// and the skid buffer occupancy states.
package tlul_pkg;

  localparam int unsigned DataMaxWidth  = 32;
  localparam int unsigned DataIntgWidth = 7;
  // XOR applied to the check bits so an all-zero word is not a valid codeword
  localparam logic [DataIntgWidth-1:0] DataIntgInv = 7'h2A;

  // Encoding doubles as the entry count
  typedef enum logic [1:0] {
    BufEmpty = 2'd0,
    BufOne   = 2'd1,
    BufFull  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/prim_secded_inv_39_32_dec.sv
// Combinational inverted SECDED(39,32) decoder with single-bit correction.
module prim_secded_inv_39_32_dec
  import tlul_pkg::*;
(
  input  logic [38:0] data_i,
  output logic [31:0] data_o,
  output logic [6:0]  syndrome_o,
  output logic [1:0]  err_o
);

  // Parity-check rows: data participation plus the check bit itself
  localparam logic [6:0][38:0] DecMask = {
    39'h40_98505586, 39'h20_2DCC624C, 39'h10_C2C1323B, 39'h08_31234ED1,
    39'h04_413D89AA, 39'h02_DEBA8050, 39'h01_2606BD25
  };

  logic [38:0] raw;
  logic [6:0]  col;

  // Undo the inversion, compute syndrome, flip the data bit it points at
  always_comb begin
    raw        = data_i ^ {DataIntgInv, 32'h0};
    syndrome_o = '0;
    data_o     = data_i[31:0];
    col        = '0;
    for (int k = 0; k < 7; k++) begin
      syndrome_o[k] = ^(raw & DecMask[k]);
    end
    for (int i = 0; i < 32; i++) begin
      for (int k = 0; k < 7; k++) begin
        col[k] = DecMask[k][i];
      end
      data_o[i] = data_i[i] ^ (syndrome_o == col);
    end
    err_o[0] = ^syndrome_o;
    err_o[1] = (|syndrome_o) & ~(^syndrome_o);
  end

endmodule

// File: rtl/prim_secded_inv_39_32_enc.sv
// Combinational inverted SECDED(39,32) encoder: {intg[6:0], data[31:0]}.
module prim_secded_inv_39_32_enc
  import tlul_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [38:0] data_o
);

  // Data-bit participation of each check bit (index k -> check bit k)
  localparam logic [6:0][31:0] EncMask = {
    32'h98505586, 32'h2DCC624C, 32'hC2C1323B, 32'h31234ED1,
    32'h413D89AA, 32'hDEBA8050, 32'h2606BD25
  };

  logic [6:0] intg;

  // Even parity per check bit, then inversion
  always_comb begin
    intg = '0;
    for (int k = 0; k < 7; k++) begin
      intg[k] = ^(data_i & EncMask[k]);
    end
    data_o = {intg ^ DataIntgInv, data_i};
  end

endmodule

// File: rtl/tlul_data_integ_enc_buf.sv
// TL-UL transmit-side data integrity encoder behind a 2-entry skid buffer.
// Outputs come straight from registers; a re-decode of the head entry
// raises a sticky alert.
module tlul_data_integ_enc_buf
  import tlul_pkg::*;
#(
  parameter int unsigned DataWidth   = DataMaxWidth,
  parameter int unsigned IntgWidth   = DataIntgWidth,
  parameter bit          EnableCheck = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [DataWidth-1:0]          data_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [DataWidth+IntgWidth-1:0] data_intg_o,
  output logic [1:0]                    count_o,
  output logic                          intg_fault_o
);

  localparam int unsigned CwWidth = DataWidth + IntgWidth;

  if (DataWidth != 32 || IntgWidth != 7) begin : g_bad_param
    $error("tlul_data_integ_enc_buf: only DataWidth=32, IntgWidth=7 supported");
  end

  buf_state_e         state_q, state_d;
  logic [CwWidth-1:0] head_q, head_d, skid_q, skid_d, enc_cw;
  logic               push, pop, chk_err, fault_q;

  prim_secded_inv_39_32_enc u_enc (
    .data_i (data_i),
    .data_o (enc_cw)
  );

  assign ready_o      = (state_q != BufFull);
  assign valid_o      = (state_q != BufEmpty);
  assign count_o      = state_q;
  assign push         = valid_i & ready_o;
  assign pop          = valid_o & ready_i;
  assign data_intg_o  = head_q;
  assign intg_fault_o = fault_q;

  // Next occupancy and entry contents; the skid entry only fills while the head is stalled
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      BufEmpty: begin
        if (push) begin
          state_d = BufOne;
          head_d  = enc_cw;
        end
      end
      BufOne: begin
        if (push && !pop) begin
          state_d = BufFull;
          skid_d  = enc_cw;
        end else if (push && pop) begin
          head_d = enc_cw;
        end else if (pop) begin
          state_d = BufEmpty;
        end
      end
      BufFull: begin
        if (pop) begin
          state_d = BufOne;
          head_d  = skid_q;
        end
      end
      default: state_d = BufEmpty;
    endcase
  end

  // Buffer registers; reset discards anything in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BufEmpty;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // Only a valid head is checked: the stale head of an empty buffer is not a codeword
  if (EnableCheck) begin : g_check
    logic [31:0] dec_data;
    logic [6:0]  dec_syn;
    logic [1:0]  dec_err;
    logic        unused_dec;

    prim_secded_inv_39_32_dec u_dec (
      .data_i     (head_q),
      .data_o     (dec_data),
      .syndrome_o (dec_syn),
      .err_o      (dec_err)
    );

    assign unused_dec = ^{dec_data, dec_syn};
    assign chk_err    = valid_o & (|dec_err);
  end else begin : g_no_check
    assign chk_err = 1'b0;
  end

  // Sticky alert, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst_i)        fault_q <= 1'b0;
    else if (chk_err) fault_q <= 1'b1;
  end

endmodule

// File: tb/tb_tlul_data_integ_enc_buf.sv
// Directed bench for tlul_data_integ_enc_buf: reset, hand-coded codewords,
// streaming, stall/skid, random handshake scoreboard, reset flush, fault alert.
module tb_tlul_data_integ_enc_buf;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] data_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [38:0] data_intg_o;
  logic [1:0]  count_o;
  logic        intg_fault_o;

  tlul_data_integ_enc_buf dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_i       (data_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_intg_o  (data_intg_o),
    .count_o      (count_o),
    .intg_fault_o (intg_fault_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned   total = 0;
  int unsigned   bad   = 0;
  logic [31:0]   q[$];
  logic          last_push = 1'b0;

  // Reference parity-check rows (check bit included), applied after removing the inversion
  function automatic logic [6:0] syn(input logic [38:0] cw);
    logic [38:0] h [7];
    logic [38:0] r;
    h[0] = 39'h01_2606BD25; h[1] = 39'h02_DEBA8050; h[2] = 39'h04_413D89AA;
    h[3] = 39'h08_31234ED1; h[4] = 39'h10_C2C1323B; h[5] = 39'h20_2DCC624C;
    h[6] = 39'h40_98505586;
    r = cw ^ 39'h2A_0000_0000;
    syn = '0;
    for (int k = 0; k < 7; k++) syn[k] = ^(r & h[k]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // One handshake cycle with scoreboard, occupancy and stall-stability checks
  task automatic cycle();
    logic        p, o, stalled;
    logic [38:0] held;
    logic [31:0] e;
    p = valid_i & ready_o;
    o = valid_o & ready_i;
    if (o) begin
      chk("sb_nonempty", q.size() > 0, 1'b1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pop_data", data_intg_o[31:0], e);
        chk("pop_syn", syn(data_intg_o), 7'd0);
      end
    end
    if (p) q.push_back(data_i);
    stalled   = valid_o & ~ready_i;
    held      = data_intg_o;
    last_push = p;
    step();
    chk("count", count_o, q.size());
    if (stalled) begin
      chk("hold_valid", valid_o, 1'b1);
      chk("hold_data", data_intg_o, held);
    end
  endtask

  logic [31:0] hv_d [3];
  logic [38:0] hv_c [3];
  logic [38:0] bad_cw;

  initial begin
    hv_d[0] = 32'h0000_0000; hv_c[0] = 39'h2A_0000_0000;
    hv_d[1] = 32'hFFFF_FFFF; hv_c[1] = 39'h2A_FFFF_FFFF;
    hv_d[2] = 32'h0000_0001; hv_c[2] = 39'h33_0000_0001;

    // Reset state
    step(); step();
    chk("rst_count", count_o, 2'd0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_data", data_intg_o, 39'd0);
    chk("rst_fault", intg_fault_o, 1'b0);

    // First word, one-cycle latency
    rst_i = 1'b0; valid_i = 1'b1; data_i = 32'h0; ready_i = 1'b0;
    step();
    valid_i = 1'b0;
    chk("first_valid", valid_o, 1'b1);
    chk("first_data", data_intg_o, 39'h2A_0000_0000);
    chk("first_fault", intg_fault_o, 1'b0);
    chk("first_count", count_o, 2'd1);
    ready_i = 1'b1;
    step();
    chk("first_drain", count_o, 2'd0);

    // Hand-computed codewords
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; data_i = hv_d[i];
      step();
      valid_i = 1'b0;
      chk("hand_cw", data_intg_o, hv_c[i]);
      step();
    end
    chk("empty_nofault", intg_fault_o, 1'b0);

    // Full-throughput stream
    for (int i = 0; i < 1000; i++) begin
      valid_i = 1'b1; ready_i = 1'b1; data_i = $urandom;
      chk("stream_ready", ready_o, 1'b1);
      cycle();
    end
    valid_i = 1'b0;
    cycle(); cycle();
    chk("stream_drained", q.size(), 0);

    // Stall into the skid entry, third word held by the source
    ready_i = 1'b0; valid_i = 1'b1; data_i = 32'h1111_1111;
    cycle();
    data_i = 32'h2222_2222;
    cycle();
    chk("stall_count", count_o, 2'd2);
    chk("stall_ready", ready_o, 1'b0);
    chk("stall_head", data_intg_o[31:0], 32'h1111_1111);
    data_i = 32'h3333_3333;
    cycle(); cycle();
    chk("stall_still_full", count_o, 2'd2);
    ready_i = 1'b1;
    cycle();
    chk("release_head", data_intg_o[31:0], 32'h2222_2222);
    cycle();
    valid_i = 1'b0;
    chk("release_head3", data_intg_o[31:0], 32'h3333_3333);
    cycle();
    chk("release_empty", count_o, 2'd0);

    // Random handshakes; source holds an unaccepted word
    last_push = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if (!(valid_i && !last_push)) begin
        valid_i = 1'($urandom_range(0, 1));
        data_i  = $urandom;
      end
      ready_i = 1'($urandom_range(0, 1));
      cycle();
    end
    valid_i = 1'b0; ready_i = 1'b1;
    cycle(); cycle(); cycle();
    chk("rand_drained", q.size(), 0);

    // Reset while full and pushing
    ready_i = 1'b0; valid_i = 1'b1; data_i = 32'hAAAA_0001;
    cycle();
    data_i = 32'hAAAA_0002;
    cycle();
    data_i = 32'hAAAA_0003;
    chk("pre_rst_full", count_o, 2'd2);
    rst_i = 1'b1;
    step();
    chk("frst_count", count_o, 2'd0);
    chk("frst_valid", valid_o, 1'b0);
    chk("frst_ready", ready_o, 1'b1);
    q.delete();
    rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("no_stale", valid_o, 1'b0);
    end

    // Corrupt the stored head: alert next edge, sticky through pop and new traffic
    ready_i = 1'b0; valid_i = 1'b1; data_i = 32'h5A5A_5A5A;
    cycle();
    valid_i = 1'b0;
    chk("pre_fault", intg_fault_o, 1'b0);
    bad_cw = data_intg_o ^ 39'h80;
    force dut.head_q = bad_cw;
    step();
    chk("fault_set", intg_fault_o, 1'b1);
    release dut.head_q;
    ready_i = 1'b1;
    step();
    q.delete();
    chk("fault_pop_valid", valid_o, 1'b0);
    chk("fault_sticky_pop", intg_fault_o, 1'b1);
    valid_i = 1'b1; data_i = 32'h0000_1234;
    step();
    valid_i = 1'b0;
    step();
    chk("fault_sticky_traffic", intg_fault_o, 1'b1);
    rst_i = 1'b1;
    step();
    chk("fault_cleared", intg_fault_o, 1'b0);
    rst_i = 1'b0;
    step();
    chk("fault_stays_clear", intg_fault_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
